// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU stage.
//  - op-code encodings seen on in_op
//  - slice function select (low two op bits)
//  - sequencer state type
//  - nibble width
package alu_pkg;

   localparam int unsigned NIB_W = 4;

   // in_op encodings: bit 2 inverts B and supplies carry-in, bits 1:0 pick the function
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   localparam logic [1:0] SEL_AND   = 2'b00;
   localparam logic [1:0] SEL_OR    = 2'b01;
   localparam logic [1:0] SEL_ARITH = 2'b10;
   localparam logic [1:0] SEL_SLT   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // SLT always subtracts; otherwise bit 2 selects B inversion / carry-in
   function automatic logic op_is_sub(input logic [2:0] op);
      return op[2] | (op[1:0] == SEL_SLT);
   endfunction

endpackage

// File: rtl/alu_nibble_slice.sv
// Combinational 4-bit ALU slice.
//  a, b   : operand nibbles
//  binv   : invert b before use
//  cin    : carry into bit 0
//  sel    : 00 AND, 01 OR, 1x sum
//  y      : selected nibble result
//  cout   : carry out of bit 3
//  c3     : carry into bit 3 (used for signed overflow on the top nibble)
module alu_nibble_slice
   import alu_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             binv,
   input  logic             cin,
   input  logic [1:0]       sel,
   output logic [NIB_W-1:0] y,
   output logic             cout,
   output logic             c3
);

   logic [NIB_W-1:0] bb;
   logic [NIB_W:0]   sum;
   logic [NIB_W-1:0] low_sum;

   always_comb begin
      bb      = b ^ {NIB_W{binv}};
      sum     = {1'b0, a} + {1'b0, bb} + {{NIB_W{1'b0}}, cin};
      // sum of the low three bits; its top bit is the carry into bit 3
      low_sum = {1'b0, a[2:0]} + {1'b0, bb[2:0]} + {{(NIB_W-1){1'b0}}, cin};
      cout    = sum[NIB_W];
      c3      = low_sum[NIB_W-1];
      unique case (sel)
         SEL_AND: y = a & bb;
         SEL_OR:  y = a | bb;
         default: y = sum[NIB_W-1:0];
      endcase
   end

endmodule

// File: rtl/alu_nibble_seq.sv
// Nibble-serial wide ALU stage. Takes WIDTH-bit operands and an op code over valid/ready,
// processes one nibble per cycle LSB-first with the carry held in a register, and returns
// result, carry-out and signed overflow over valid/ready. One request in flight at a time.
//
// Ports:
//  clk, rst_n                  clock, asynchronous active-low reset
//  in_valid/in_ready           request handshake (in_ready only while idle)
//  in_a, in_b, in_op           operands and op (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
//  out_valid/out_ready         result handshake; outputs held stable until accepted
//  out_result                  result
//  out_cout                    carry out of MSB for ADD/SUB, else 0
//  out_overflow                signed overflow for ADD/SUB, else 0
//  out_zero, out_neg           result==0 and result MSB; present only when
//                              ALU_NIBBLE_SEQ_ZERO_FLAG_EN is defined
//
// Latency from accepted request to out_valid is WIDTH/4 + 1 cycles: one per nibble, then
// one cycle to form the final result/flags into the output registers.
module alu_nibble_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
   output logic             out_zero,
   output logic             out_neg,
`endif
   output logic             out_overflow
);

   localparam int unsigned N     = WIDTH / NIB_W;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [1:0]         sel_q, sel_d;
   logic               binv_q, binv_d;
   logic               carry_q, carry_d;
   logic               msb_cin_q, msb_cin_d;
   logic               msb_cout_q, msb_cout_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_result_q, out_result_d;
   logic               out_cout_q, out_cout_d;
   logic               out_ovf_q, out_ovf_d;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
   logic               zero_acc_q, zero_acc_d;
   logic               out_zero_q, out_zero_d;
   logic               out_neg_q, out_neg_d;
`endif

   logic [NIB_W-1:0]   slice_y;
   logic               slice_cout;
   logic               slice_c3;
   logic               ovf;
   logic               slt_bit;
   logic               sub;

   alu_nibble_slice u_slice (
      .a    (a_q[NIB_W-1:0]),
      .b    (b_q[NIB_W-1:0]),
      .binv (binv_q),
      .cin  (carry_q),
      .sel  (sel_q),
      .y    (slice_y),
      .cout (slice_cout),
      .c3   (slice_c3)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      a_d          = a_q;
      b_d          = b_q;
      res_d        = res_q;
      sel_d        = sel_q;
      binv_d       = binv_q;
      carry_d      = carry_q;
      msb_cin_d    = msb_cin_q;
      msb_cout_d   = msb_cout_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_cout_d   = out_cout_q;
      out_ovf_d    = out_ovf_q;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
      zero_acc_d   = zero_acc_q;
      out_zero_d   = out_zero_q;
      out_neg_d    = out_neg_q;
`endif
      sub          = op_is_sub(in_op);
      ovf          = msb_cin_q ^ msb_cout_q;
      slt_bit      = res_q[WIDTH-1] ^ ovf;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               sel_d   = in_op[1:0];
               binv_d  = sub;
               carry_d = sub;
               idx_d   = '0;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
               zero_acc_d = 1'b1;
`endif
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_d     = a_q >> NIB_W;
            b_d     = b_q >> NIB_W;
            // result fills from the top so nibble 0 ends up at the bottom after N shifts
            res_d   = {slice_y, res_q[WIDTH-1:NIB_W]};
            carry_d = slice_cout;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
            zero_acc_d = zero_acc_q & (slice_y == '0);
`endif
            if (idx_q == IDX_W'(N - 1)) begin
               msb_cin_d  = slice_c3;
               msb_cout_d = slice_cout;
               state_d    = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (!out_valid_q) begin
               // first DONE cycle: form the architectural result from the collected nibbles
               out_valid_d = 1'b1;
               unique case (sel_q)
                  SEL_ARITH: begin
                     out_result_d = res_q;
                     out_cout_d   = msb_cout_q;
                     out_ovf_d    = ovf;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
                     out_zero_d   = zero_acc_q;
                     out_neg_d    = res_q[WIDTH-1];
`endif
                  end
                  SEL_SLT: begin
                     out_result_d = {{(WIDTH-1){1'b0}}, slt_bit};
                     out_cout_d   = 1'b0;
                     out_ovf_d    = 1'b0;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
                     out_zero_d   = ~slt_bit;
                     out_neg_d    = 1'b0;
`endif
                  end
                  default: begin
                     out_result_d = res_q;
                     out_cout_d   = 1'b0;
                     out_ovf_d    = 1'b0;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
                     out_zero_d   = zero_acc_q;
                     out_neg_d    = res_q[WIDTH-1];
`endif
                  end
               endcase
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         res_q        <= '0;
         sel_q        <= '0;
         binv_q       <= 1'b0;
         carry_q      <= 1'b0;
         msb_cin_q    <= 1'b0;
         msb_cout_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_cout_q   <= 1'b0;
         out_ovf_q    <= 1'b0;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
         zero_acc_q   <= 1'b0;
         out_zero_q   <= 1'b0;
         out_neg_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         a_q          <= a_d;
         b_q          <= b_d;
         res_q        <= res_d;
         sel_q        <= sel_d;
         binv_q       <= binv_d;
         carry_q      <= carry_d;
         msb_cin_q    <= msb_cin_d;
         msb_cout_q   <= msb_cout_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_cout_q   <= out_cout_d;
         out_ovf_q    <= out_ovf_d;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
         zero_acc_q   <= zero_acc_d;
         out_zero_q   <= out_zero_d;
         out_neg_q    <= out_neg_d;
`endif
      end
   end

   assign in_ready     = (state_q == ST_IDLE);
   assign out_valid    = out_valid_q;
   assign out_result   = out_result_q;
   assign out_cout     = out_cout_q;
   assign out_overflow = out_ovf_q;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
   assign out_zero     = out_zero_q;
   assign out_neg      = out_neg_q;
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq (WIDTH=16): random and directed requests checked against a
// plain-arithmetic model; one negedge monitor compares handshake and outputs every cycle.
module tb_alu_nibble_seq;

   localparam int W   = 16;
   localparam int LAT = W / 4 + 1;

   typedef struct {
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
      logic         zero;
      logic         neg;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [2:0]   in_op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;
   logic         out_cout;
   logic         out_overflow;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
   logic         out_zero;
   logic         out_neg;
`endif

   int   n_vec;
   int   n_err;
   int   cyc;
   int   acc_cyc;
   bit   busy;
   bit   hold_ready;
   exp_t exp_q[$];
   exp_t last;

   alu_nibble_seq #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_op        (in_op),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_cout     (out_cout),
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
      .out_zero     (out_zero),
      .out_neg      (out_neg),
`endif
      .out_overflow (out_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: two's-complement arithmetic on whole words.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] op);
      exp_t         e;
      logic         sub;
      logic [W-1:0] bb;
      logic [W:0]   full;
      logic [W-1:0] s;
      logic         v;
      sub  = op[2] || (op[1:0] == 2'b11);
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + (W+1)'(sub);
      s    = full[W-1:0];
      v    = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
      e.cout = 1'b0;
      e.ovf  = 1'b0;
      case (op[1:0])
         2'b00: e.res = a & bb;
         2'b01: e.res = a | bb;
         2'b10: begin
            e.res  = s;
            e.cout = full[W];
            e.ovf  = v;
         end
         default: e.res = W'(s[W-1] ^ v);
      endcase
      e.zero = (e.res == '0);
      e.neg  = e.res[W-1];
      return e;
   endfunction

   // Monitor: sampled mid-cycle, when all DUT outputs and bench inputs are settled.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
         chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
         chk("rst_out_result", {16'b0, out_result}, 32'd0);
         chk("rst_out_cout", {31'b0, out_cout}, 32'd0);
         chk("rst_out_overflow", {31'b0, out_overflow}, 32'd0);
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
         chk("rst_out_zero", {31'b0, out_zero}, 32'd0);
         chk("rst_out_neg", {31'b0, out_neg}, 32'd0);
`endif
         busy = 1'b0;
         exp_q.delete();
      end else begin
         chk("in_ready", {31'b0, in_ready}, {31'b0, !busy});
         chk("out_valid", {31'b0, out_valid}, {31'b0, busy && (cyc >= acc_cyc + LAT)});
         if (out_valid && busy && exp_q.size() > 0) begin
            chk("out_result", {16'b0, out_result}, {16'b0, exp_q[0].res});
            chk("out_cout", {31'b0, out_cout}, {31'b0, exp_q[0].cout});
            chk("out_overflow", {31'b0, out_overflow}, {31'b0, exp_q[0].ovf});
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
            chk("out_zero", {31'b0, out_zero}, {31'b0, exp_q[0].zero});
            chk("out_neg", {31'b0, out_neg}, {31'b0, exp_q[0].neg});
`endif
            if (out_ready) begin
               last.res  = out_result;
               last.cout = out_cout;
               last.ovf  = out_overflow;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
               last.zero = out_zero;
               last.neg  = out_neg;
`endif
               void'(exp_q.pop_front());
               busy = 1'b0;
            end
         end else if (in_valid && in_ready && !busy) begin
            busy    = 1'b1;
            acc_cyc = cyc + 1;
            exp_q.push_back(model(in_a, in_b, in_op));
         end
      end
   end

   // Consumer: mostly ready, stalls now and then.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
      int k;
      @(posedge clk);
      #1;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_valid = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k = k + 1;
      end while (!in_ready && k < 50);
      if (!in_ready) begin
         n_vec = n_vec + 1;
         n_err = n_err + 1;
         $display("FAIL accept_timeout: in_ready stuck at 0, expected 1 within 50 cycles");
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (busy && k < 100) begin
         @(posedge clk);
         k = k + 1;
      end
      if (busy) begin
         n_vec = n_vec + 1;
         n_err = n_err + 1;
         $display("FAIL result_timeout: out_valid/out_ready handshake absent, expected within 100");
         do_reset();
      end
   endtask

   task automatic run_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic [W-1:0] r, input logic c,
                          input logic v);
      do_op(a, b, op);
      wait_done();
      chk({name, "_result"}, {16'b0, last.res}, {16'b0, r});
      chk({name, "_cout"}, {31'b0, last.cout}, {31'b0, c});
      chk({name, "_ovf"}, {31'b0, last.ovf}, {31'b0, v});
   endtask

   initial begin
      int k;
      n_vec      = 0;
      n_err      = 0;
      cyc        = 0;
      acc_cyc    = 0;
      busy       = 1'b0;
      hold_ready = 1'b0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_a       = '0;
      in_b       = '0;
      in_op      = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Hand-computed expectations
      run_lit("add_7fff_1", 16'h7FFF, 16'h0001, 3'b010, 16'h8000, 1'b0, 1'b1);
      run_lit("sub_5_7", 16'h0005, 16'h0007, 3'b110, 16'hFFFE, 1'b0, 1'b0);
      run_lit("sub_7_5", 16'h0007, 16'h0005, 3'b110, 16'h0002, 1'b1, 1'b0);
      run_lit("slt_8000_1", 16'h8000, 16'h0001, 3'b111, 16'h0001, 1'b0, 1'b0);
      run_lit("slt_7fff_8000", 16'h7FFF, 16'h8000, 3'b111, 16'h0000, 1'b0, 1'b0);
      run_lit("and", 16'hF0F0, 16'h0FF0, 3'b000, 16'h00F0, 1'b0, 1'b0);
      run_lit("or", 16'hF0F0, 16'h0FF0, 3'b001, 16'hFFF0, 1'b0, 1'b0);
      run_lit("slt_op011", 16'hFFFF, 16'h0000, 3'b011, 16'h0001, 1'b0, 1'b0);
      run_lit("andn", 16'hFFFF, 16'h00FF, 3'b100, 16'hFF00, 1'b0, 1'b0);
      run_lit("add_carry", 16'hFFFF, 16'h0001, 3'b010, 16'h0000, 1'b1, 1'b0);
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
      run_lit("sub_eq", 16'h1234, 16'h1234, 3'b110, 16'h0000, 1'b1, 1'b0);
      chk("sub_eq_zero", {31'b0, last.zero}, 32'd1);
      chk("sub_eq_neg", {31'b0, last.neg}, 32'd0);
`endif

      // Stall in DONE for three cycles while offering a request that must be ignored
      hold_ready = 1'b1;
      do_op(16'h1111, 16'h2222, 3'b010);
      k = 0;
      while (!out_valid && k < 50) begin
         @(negedge clk);
         k = k + 1;
      end
      chk("stall_reached_done", {31'b0, out_valid}, 32'd1);
      repeat (3) begin
         @(posedge clk);
         #2;
         in_valid = 1'b1;
         in_a     = 16'(($urandom));
         in_b     = 16'(($urandom));
         in_op    = 3'b001;
      end
      @(negedge clk);
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_result", {16'b0, out_result}, 32'h3333);
      @(posedge clk);
      #2 in_valid = 1'b0;
      hold_ready = 1'b0;
      wait_done();
      chk("stall_last", {16'b0, last.res}, 32'h3333);

      // Asynchronous reset while nibble 2 is in flight
      do_op(16'h1234, 16'h4321, 3'b010);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_lit("after_rst", 16'h1234, 16'h4321, 3'b010, 16'h5555, 1'b0, 1'b0);

      // Random traffic, with extra weight on sign-boundary operands
      for (int i = 0; i < 150; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = 16'($urandom);
         b = 16'($urandom);
         if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) != 0, {(W-1){a[0]}}};
         if ($urandom_range(0, 3) == 0) b = {$urandom_range(0, 1) != 0, {(W-1){b[0]}}};
         if ($urandom_range(0, 7) == 0) b = a;
         do_op(a, b, 3'($urandom_range(0, 7)));
         wait_done();
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
